// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage.
// Word type, HALT encoding and fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  word_t imemload;
  logic  ihit;

  modport master (
    output imemREN,
    output imemaddr,
    input  imemload,
    input  ihit
  );

  modport slave (
    input  imemREN,
    input  imemaddr,
    output imemload,
    output ihit
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID holding register.
// Priority: flush, load, hold, else drain.
module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  hold,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t npc_in,
  output logic  valid,
  output word_t instr,
  output word_t npc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      npc   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      npc   <= npc_in;
    end else if (!hold) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: request, next-PC,
// HALT/redirect FSM and IF/ID capture.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000,
  parameter word_t PC_INCR  = 32'd4
) (
  input  logic  CLK,
  input  logic  RST,
  input  word_t pc_curr,
  output word_t pc_next,
  output logic  pc_en,
  fetch_unit_if.master imem,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_npc,
  output logic  halted,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  word_t pc_inc;
  logic  hold;
  logic  accept;
  logic  is_halt;

  assign pc_inc  = pc_curr + PC_INCR;
  assign hold    = stall && ifid_valid;
  assign is_halt = (imem.imemload == HALT_INSTR);

  assign imem.imemaddr = pc_curr;
  // Gated by RST so a late response during reset is ignored.
  assign imem.imemREN  = !RST && (state == FETCH)
                      && !redirect_valid && !hold;
  assign accept = imem.imemREN && imem.ihit;

  always_comb begin
    pc_en   = 1'b0;
    pc_next = pc_inc;
    if (RST) begin
      pc_next = PC_RESET;
    end else if (redirect_valid) begin
      pc_en   = 1'b1;
      pc_next = redirect_pc;
    end else if (accept && !is_halt) begin
      pc_en   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FETCH;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      state  <= FETCH;
      halted <= 1'b0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
      if (is_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

  ifid_reg u_ifid (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .hold     (hold),
    .flush    (redirect_valid),
    .instr_in (imem.imemload),
    .npc_in   (pc_inc),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .npc      (ifid_npc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  typedef struct {
    word_t instr;
    word_t npc;
  } exp_t;

  logic  CLK = 1'b0;
  logic  RST;
  word_t pc_curr;
  word_t pc_next;
  logic  pc_en;
  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_npc;
  logic  halted;
  logic [31:0] fetch_count;

  fetch_unit_if imem();

  fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .pc_curr        (pc_curr),
    .pc_next        (pc_next),
    .pc_en          (pc_en),
    .imem           (imem),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_npc       (ifid_npc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 CLK = ~CLK;

  int    vectors = 0;
  int    miscompares = 0;
  int unsigned cnt = 0;
  exp_t  sb[$];
  exp_t  e;
  word_t held;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  function automatic word_t rnd_instr();
    word_t w;
    w = $urandom;
    if (w == HALT_INSTR) w = 32'h0;
    return w;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    pc_curr = 32'h0000_0020;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem.ihit = 1'b1;
    imem.imemload = 32'h2001_0005;
    repeat (2) settle();
    vectors++;
    if ({pc_en, imem.imemREN, pc_next} !== {2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_pc got en=%b ren=%b nxt=%h want 0/0/0",
               pc_en, imem.imemREN, pc_next);
    end
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc} !== 65'b0) begin
      miscompares++;
      $display("FAIL rst_ifid got %b/%h/%h want 0/0/0",
               ifid_valid, ifid_instr, ifid_npc);
    end
    vectors++;
    if ({halted, fetch_count} !== 33'b0) begin
      miscompares++;
      $display("FAIL rst_cnt got h=%b c=%0d want 0/0", halted, fetch_count);
    end
    vectors++;
    if (imem.imemaddr !== 32'h20) begin
      miscompares++;
      $display("FAIL rst_addr got %h want 20", imem.imemaddr);
    end
    tick();
    RST = 1'b0;
    imem.ihit = 1'b0;
    pc_curr = 32'h0;
    settle();
    vectors++;
    if ({imem.imemREN, pc_en, halted} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_rel got ren=%b en=%b h=%b want 1/0/0",
               imem.imemREN, pc_en, halted);
    end
  endtask

  task automatic test_sequential();
    word_t w;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 32'h2001_0005 : rnd_instr();
      tick();
      imem.ihit = 1'b1;
      imem.imemload = w;
      settle();
      vectors++;
      if ({pc_en, pc_next} !== {1'b1, pc_curr + 32'd4}) begin
        miscompares++;
        $display("FAIL seq_pc got en=%b nxt=%h want 1/%h",
                 pc_en, pc_next, pc_curr + 32'd4);
      end
      vectors++;
      if (imem.imemaddr !== pc_curr) begin
        miscompares++;
        $display("FAIL seq_addr got %h want %h", imem.imemaddr, pc_curr);
      end
      sb.push_back('{w, pc_curr + 32'd4});
      tick();
      pc_curr = pc_curr + 32'd4;
      cnt++;
      imem.ihit = 1'b0;
      imem.imemload = 32'hDEAD_BEEF;
      settle();
      e = sb.pop_front();
      vectors++;
      if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, e.instr, e.npc}) begin
        miscompares++;
        $display("FAIL seq_ifid got %b/%h/%h want 1/%h/%h",
                 ifid_valid, ifid_instr, ifid_npc, e.instr, e.npc);
      end
      vectors++;
      if ({fetch_count, pc_en, imem.imemREN} !== {cnt, 2'b01}) begin
        miscompares++;
        $display("FAIL seq_cnt got c=%0d en=%b ren=%b want %0d/0/1",
                 fetch_count, pc_en, imem.imemREN, cnt);
      end
    end
  endtask

  task automatic test_stall_hold();
    held = 32'h0AAA_0001;
    tick();
    imem.ihit = 1'b1;
    imem.imemload = held;
    settle();
    sb.push_back('{held, pc_curr + 32'd4});
    tick();
    stall = 1'b1;
    imem.imemload = 32'h1111_2222;
    pc_curr = pc_curr + 32'd4;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, e.instr, e.npc}) begin
      miscompares++;
      $display("FAIL stall_load got %b/%h/%h want 1/%h/%h",
               ifid_valid, ifid_instr, ifid_npc, e.instr, e.npc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        settle();
      end
      vectors++;
      if ({imem.imemREN, pc_en, ifid_valid, ifid_instr, fetch_count}
          !== {3'b001, held, cnt}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got ren=%b en=%b v=%b i=%h c=%0d",
                 i, imem.imemREN, pc_en, ifid_valid, ifid_instr, fetch_count);
      end
    end
    tick();
    stall = 1'b0;
    imem.ihit = 1'b0;
    settle();
    vectors++;
    if ({imem.imemREN, imem.imemaddr, ifid_valid} !== {1'b1, pc_curr, 1'b1}) begin
      miscompares++;
      $display("FAIL stall_rel got ren=%b a=%h v=%b want 1/%h/1",
               imem.imemREN, imem.imemaddr, ifid_valid, pc_curr);
    end
    tick();
    stall = 1'b1;
    settle();
    vectors++;
    if ({ifid_valid, imem.imemREN} !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_bubble got v=%b ren=%b want 0/1",
               ifid_valid, imem.imemREN);
    end
    tick();
    imem.ihit = 1'b1;
    imem.imemload = 32'h0AAA_0002;
    settle();
    vectors++;
    if ({pc_en, pc_next} !== {1'b1, pc_curr + 32'd4}) begin
      miscompares++;
      $display("FAIL stall_fill got en=%b nxt=%h want 1/%h",
               pc_en, pc_next, pc_curr + 32'd4);
    end
    sb.push_back('{32'h0AAA_0002, pc_curr + 32'd4});
    tick();
    stall = 1'b0;
    imem.ihit = 1'b0;
    pc_curr = pc_curr + 32'd4;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc, fetch_count}
        !== {1'b1, e.instr, e.npc, cnt}) begin
      miscompares++;
      $display("FAIL stall_fill_ifid got %b/%h/%h/%0d want 1/%h/%h/%0d",
               ifid_valid, ifid_instr, ifid_npc, fetch_count,
               e.instr, e.npc, cnt);
    end
  endtask

  task automatic test_redirect();
    tick();
    imem.ihit = 1'b1;
    imem.imemload = 32'h0BBB_0001;
    settle();
    sb.push_back('{32'h0BBB_0001, pc_curr + 32'd4});
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    stall = 1'b1;
    imem.imemload = 32'h5555_5555;
    pc_curr = pc_curr + 32'd4;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, e.instr, e.npc}) begin
      miscompares++;
      $display("FAIL redir_pre got %b/%h/%h want 1/%h/%h",
               ifid_valid, ifid_instr, ifid_npc, e.instr, e.npc);
    end
    vectors++;
    if ({pc_en, imem.imemREN, pc_next} !== {2'b10, 32'h100}) begin
      miscompares++;
      $display("FAIL redir_pc got en=%b ren=%b nxt=%h want 1/0/100",
               pc_en, imem.imemREN, pc_next);
    end
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    imem.ihit = 1'b0;
    pc_curr = 32'h0000_0100;
    settle();
    vectors++;
    if ({ifid_valid, fetch_count} !== {1'b0, cnt}) begin
      miscompares++;
      $display("FAIL redir_flush got v=%b c=%0d want 0/%0d",
               ifid_valid, fetch_count, cnt);
    end
    vectors++;
    if ({imem.imemREN, imem.imemaddr} !== {1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL redir_req got ren=%b a=%h want 1/100",
               imem.imemREN, imem.imemaddr);
    end
  endtask

  task automatic test_halt();
    tick();
    imem.ihit = 1'b1;
    imem.imemload = HALT_INSTR;
    settle();
    vectors++;
    if ({pc_en, imem.imemREN} !== 2'b01) begin
      miscompares++;
      $display("FAIL halt_acc got en=%b ren=%b want 0/1", pc_en, imem.imemREN);
    end
    sb.push_back('{HALT_INSTR, pc_curr + 32'd4});
    tick();
    imem.imemload = 32'h2001_0005;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc} !== {1'b1, e.instr, e.npc}) begin
      miscompares++;
      $display("FAIL halt_ifid got %b/%h/%h want 1/%h/%h",
               ifid_valid, ifid_instr, ifid_npc, e.instr, e.npc);
    end
    vectors++;
    if ({halted, imem.imemREN, pc_en, fetch_count} !== {3'b100, cnt}) begin
      miscompares++;
      $display("FAIL halt_state got h=%b ren=%b en=%b c=%0d want 1/0/0/%0d",
               halted, imem.imemREN, pc_en, fetch_count, cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      vectors++;
      if ({halted, imem.imemREN, pc_en, ifid_valid, fetch_count}
          !== {4'b1000, cnt}) begin
        miscompares++;
        $display("FAIL halt_hold%0d got h=%b ren=%b en=%b v=%b c=%0d",
                 i, halted, imem.imemREN, pc_en, ifid_valid, fetch_count);
      end
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    settle();
    vectors++;
    if ({pc_en, pc_next} !== {1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL halt_redir got en=%b nxt=%h want 1/40", pc_en, pc_next);
    end
    tick();
    redirect_valid = 1'b0;
    imem.ihit = 1'b0;
    pc_curr = 32'h0000_0040;
    settle();
    vectors++;
    if ({halted, imem.imemREN, imem.imemaddr} !== {2'b01, 32'h40}) begin
      miscompares++;
      $display("FAIL halt_exit got h=%b ren=%b a=%h want 0/1/40",
               halted, imem.imemREN, imem.imemaddr);
    end
  endtask

  task automatic test_wrap();
    tick();
    pc_curr = 32'hFFFF_FFFC;
    imem.ihit = 1'b1;
    imem.imemload = 32'h1234_5678;
    settle();
    vectors++;
    if ({pc_en, pc_next} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_pc got en=%b nxt=%h want 1/0", pc_en, pc_next);
    end
    sb.push_back('{32'h1234_5678, 32'h0});
    tick();
    imem.ihit = 1'b0;
    pc_curr = 32'h0;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc, fetch_count}
        !== {1'b1, e.instr, e.npc, cnt}) begin
      miscompares++;
      $display("FAIL wrap_ifid got %b/%h/%h/%0d want 1/%h/%h/%0d",
               ifid_valid, ifid_instr, ifid_npc, fetch_count,
               e.instr, e.npc, cnt);
    end
  endtask

  task automatic test_back_to_back();
    word_t w;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i > 0) begin
        pc_curr = pc_curr + 32'd4;
        cnt++;
      end
      w = rnd_instr();
      imem.ihit = (i < 6);
      imem.imemload = w;
      settle();
      if (i > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({ifid_valid, ifid_instr, ifid_npc, fetch_count}
            !== {1'b1, e.instr, e.npc, cnt}) begin
          miscompares++;
          $display("FAIL b2b_ifid%0d got %b/%h/%h/%0d want 1/%h/%h/%0d",
                   i, ifid_valid, ifid_instr, ifid_npc, fetch_count,
                   e.instr, e.npc, cnt);
        end
      end
      if (i < 6) begin
        vectors++;
        if ({pc_en, pc_next} !== {1'b1, pc_curr + 32'd4}) begin
          miscompares++;
          $display("FAIL b2b_pc%0d got en=%b nxt=%h want 1/%h",
                   i, pc_en, pc_next, pc_curr + 32'd4);
        end
        sb.push_back('{w, pc_curr + 32'd4});
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    pc_curr = 32'h0000_0200;
    imem.ihit = 1'b1;
    imem.imemload = 32'h3333_0000;
    settle();
    sb.push_back('{32'h3333_0000, 32'h204});
    tick();
    imem.ihit = 1'b0;
    pc_curr = 32'h0000_0204;
    cnt++;
    settle();
    e = sb.pop_front();
    vectors++;
    if ({ifid_valid, ifid_instr, fetch_count, imem.imemREN}
        !== {1'b1, e.instr, cnt, 1'b1}) begin
      miscompares++;
      $display("FAIL arst_pre got v=%b i=%h c=%0d ren=%b",
               ifid_valid, ifid_instr, fetch_count, imem.imemREN);
    end
    #2;
    RST = 1'b1;
    imem.ihit = 1'b1;
    #1;
    cnt = 0;
    vectors++;
    if ({ifid_valid, ifid_instr, ifid_npc, fetch_count, halted} !== 98'b0) begin
      miscompares++;
      $display("FAIL arst_regs got v=%b i=%h n=%h c=%0d h=%b want zeros",
               ifid_valid, ifid_instr, ifid_npc, fetch_count, halted);
    end
    vectors++;
    if ({pc_en, imem.imemREN, pc_next} !== {2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL arst_comb got en=%b ren=%b nxt=%h want 0/0/0",
               pc_en, imem.imemREN, pc_next);
    end
    tick();
    RST = 1'b0;
    imem.ihit = 1'b0;
    pc_curr = 32'h0;
    settle();
    vectors++;
    if ({imem.imemREN, ifid_valid, fetch_count} !== {2'b10, cnt}) begin
      miscompares++;
      $display("FAIL arst_rel got ren=%b v=%b c=%0d want 1/0/0",
               imem.imemREN, ifid_valid, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
